car_dash_engine: RTL and testbench
==================================

Name: car_dash_engine

Overview:
- Parametrised game core for the LED-matrix car dash game; generalises the fixed two-player, 6-lane, 24-row engine to N players, configurable lane width, road length, spawn period and post-crash immunity.
- On each frame tick it:
  - scrolls every road one row;
  - spawns obstacle rows from external random bits;
  - applies player moves;
  - detects collisions internally;
  - updates per-player crash counters;
  - emits a flattened frame bitmap for the board-mapping and serialiser stage.

Parameters:
- NUM_PLAYERS, 2, number of independent roads/cars.
- LANE_W, 6, drivable cells per road. Each road also has one wall cell on each side.
- ROAD_LEN, 24, rows per road. Row 0 is the spawn row.
- HEAD_ROW, 16, row index of the car head. The tail occupies HEAD_ROW+1; requires HEAD_ROW+1 < ROAD_LEN.
- SPAWN_PERIOD, 4, frames between obstacle rows, 1..16.
- IMMUNITY, 3, frames after a crash during which further crashes are not counted, 0..15.
- CNT_W, 6, width of each player crash counter.

Ports:
- clk  in  1  system clock.
- RST  in  1  asynchronous active-high reset.
- run  in  1  level; ticks are ignored while low.
- tick  in  1  one-cycle frame strobe.
- move  in  2*NUM_PLAYERS  per-player move, player p in bits [2p+1:2p]: 00 hold, 01 pos-1, 10 pos+1, 11 hold.
- rand_in  in  LANE_W*NUM_PLAYERS  random obstacle bits; player p uses slice [LANE_W*p +: LANE_W]; sampled in SPAWN.
- frame  out  NUM_PLAYERS*(LANE_W+2)*ROAD_LEN  bitmap. Bit index is ((p*ROAD_LEN+r)*(LANE_W+2)+c); c=0 and c=LANE_W+1 are walls. Contents are obstacles OR car cells.
- frame_valid  out  1  one-cycle pulse when frame has been updated.
- busy  out  1  high while the FSM is not in IDLE.
- car_pos  out  4*NUM_PLAYERS  per-player lane position, 0..LANE_W-1.
- crash  out  NUM_PLAYERS  one-cycle per-player crash pulse, coincident with frame_valid.
- crash_cnt  out  CNT_W*NUM_PLAYERS  per-player counted crashes.

Behaviour:
- Reset (asynchronous, any state):
  - FSM returns to IDLE.
  - All obstacle cells cleared; wall cells set to 1.
  - car_pos = LANE_W/2 (3 with defaults).
  - crash_cnt = 0, immunity counters = 0, spawn counter = 0.
  - frame_valid, crash and busy all 0.
  - frame shows walls plus cars at HEAD_ROW and HEAD_ROW+1.
- FSM states: IDLE, SHIFT, SPAWN, MOVE, CHECK, DONE. One cycle each except IDLE.
- IDLE: run & tick -> SHIFT. A tick while busy or while run=0 is dropped, with no queueing.
- SHIFT: row r takes row r-1 for r = ROAD_LEN-1 down to 1; row ROAD_LEN-1 content is discarded. Car cells are not part of the obstacle store and do not scroll.
- SPAWN:
  - If spawn counter == 0, row 0 = the player's rand_in slice; otherwise row 0 = 0.
  - If a slice is all ones, bit (frame count mod LANE_W) is forced to 0 so the row always has a gap.
  - Spawn counter increments and wraps at SPAWN_PERIOD-1.
- MOVE:
  - 01 -> pos-1, 10 -> pos+1, 00/11 -> hold.
  - A move that would leave 0..LANE_W-1 is clamped (pos unchanged) and flagged as a wall hit.
- CHECK:
  - A player collides if the obstacle at (HEAD_ROW, pos) or (HEAD_ROW+1, pos) is 1, or on a wall hit.
  - If the player collides and its immunity counter == 0:
    - crash_cnt increments, saturating at 2^CNT_W-1;
    - immunity counter loads IMMUNITY;
    - the crash pulse is armed.
  - Otherwise a nonzero immunity counter decrements by 1.
  - The obstacle cell is not cleared.
- DONE: frame register is updated, then frame_valid and armed crash pulses are asserted for exactly one cycle, then -> IDLE.
- Latency: tick sampled in cycle T -> frame_valid and crash high in cycle T+5; busy high T+1..T+5.
- Players are fully independent; simultaneous crashes on several players are all counted in the same frame.
- frame, car_pos and crash_cnt are stable outside DONE.
- The car position index uses 4 bits per player, so LANE_W is limited to 16 or less.

Test Plan:
- Reset, no ticks -> all crash_cnt 0, car_pos 3/3, frame shows walls in c=0 and c=7 for all 24 rows, car bits at rows 16 and 17 col 4, no obstacle bits.
- run=1, rand_in=0, 10 ticks with move=01 for both players -> positions 2,1,0,0,...; wall hit counted on tick 4 (crash pulse at T+5, crash_cnt=1); no further count until IMMUNITY expires; 3 subsequent clamped ticks give one more count on tick 8.
- rand_in slice = 6'b001000 on first tick, then 0; hold pos 3 -> obstacle reaches row 16 on tick 17 and collides: crash pulse, crash_cnt=1. Same obstacle in row 17 on tick 18 is not counted (immunity).
- rand_in all ones on a spawn frame -> spawned row has exactly one 0 at bit (frame count mod 6); run=0 ticks produce no frame_valid and no state change.
- Tick asserted during busy (cycle T+2) -> ignored; exactly one frame_valid at T+5. Assert RST at T+3 -> immediate reset values, no frame_valid.
- NUM_PLAYERS=3, LANE_W=4 build: independent moves/crashes per player; crash_cnt saturates at 63 after 64+ counted crashes.

Source files
------------

// File: rtl/car_dash_engine.sv
// LED-matrix car dash game core: per-frame scroll, spawn, move, collision check
// and crash accounting for NUM_PLAYERS independent roads.
module car_dash_engine #(
  parameter int unsigned NUM_PLAYERS  = 2,
  parameter int unsigned LANE_W       = 6,
  parameter int unsigned ROAD_LEN     = 24,
  parameter int unsigned HEAD_ROW     = 16,
  parameter int unsigned SPAWN_PERIOD = 4,
  parameter int unsigned IMMUNITY     = 3,
  parameter int unsigned CNT_W        = 6
) (
  input  logic                                        clk,
  input  logic                                        RST,
  input  logic                                        run,
  input  logic                                        tick,
  input  logic [2*NUM_PLAYERS-1:0]                    move,
  input  logic [LANE_W*NUM_PLAYERS-1:0]               rand_in,
  output logic [NUM_PLAYERS*(LANE_W+2)*ROAD_LEN-1:0]  frame,
  output logic                                        frame_valid,
  output logic                                        busy,
  output logic [4*NUM_PLAYERS-1:0]                    car_pos,
  output logic [NUM_PLAYERS-1:0]                      crash,
  output logic [CNT_W*NUM_PLAYERS-1:0]                crash_cnt
);

  localparam int unsigned ROW_W    = LANE_W + 2;
  localparam int unsigned FRAME_W  = NUM_PLAYERS * ROW_W * ROAD_LEN;
  localparam int unsigned OBS_W    = NUM_PLAYERS * ROAD_LEN * LANE_W;
  localparam int unsigned POS_W    = 4 * NUM_PLAYERS;
  localparam int unsigned POS_INIT = LANE_W / 2;

  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_SPAWN, S_MOVE, S_CHECK, S_DONE} state_t;

  // Walls on both edges, obstacles in between, car drawn over head and tail rows
  function automatic logic [FRAME_W-1:0] build_frame(input logic [OBS_W-1:0] obs,
                                                     input logic [POS_W-1:0] pos);
    logic [FRAME_W-1:0] f;
    f = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      for (int r = 0; r < ROAD_LEN; r++) begin
        f[(p*ROAD_LEN + r)*ROW_W]             = 1'b1;
        f[(p*ROAD_LEN + r)*ROW_W + ROW_W - 1] = 1'b1;
        for (int c = 0; c < LANE_W; c++) begin
          f[(p*ROAD_LEN + r)*ROW_W + c + 1] = obs[(p*ROAD_LEN + r)*LANE_W + c] |
            ((pos[4*p +: 4] == 4'(c)) && (r == HEAD_ROW || r == HEAD_ROW + 1));
        end
      end
    end
    return f;
  endfunction

  localparam logic [POS_W-1:0]   POS_RST   = {NUM_PLAYERS{4'(POS_INIT)}};
  localparam logic [FRAME_W-1:0] FRAME_RST = build_frame('0, POS_RST);

  state_t                        state_q, state_d;
  logic [OBS_W-1:0]              obs_q, obs_d;
  logic [POS_W-1:0]              pos_q, pos_d;
  logic [NUM_PLAYERS-1:0]        wall_hit_q, wall_hit_d;
  logic [4*NUM_PLAYERS-1:0]      imm_q, imm_d;
  logic [CNT_W*NUM_PLAYERS-1:0]  cnt_q, cnt_d;
  logic [3:0]                    spawn_q, spawn_d;
  logic [3:0]                    fmod_q, fmod_d;
  logic [FRAME_W-1:0]            frame_q, frame_d;
  logic                          frame_valid_q, frame_valid_d;
  logic                          busy_q, busy_d;
  logic [POS_W-1:0]              car_pos_q, car_pos_d;
  logic [NUM_PLAYERS-1:0]        crash_q, crash_d;

  logic [LANE_W-1:0]             spawn_row;
  logic [3:0]                    cur_pos;
  logic                          hit;
  int unsigned                   head_idx;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q       <= S_IDLE;
      obs_q         <= '0;
      pos_q         <= POS_RST;
      wall_hit_q    <= '0;
      imm_q         <= '0;
      cnt_q         <= '0;
      spawn_q       <= '0;
      fmod_q        <= '0;
      frame_q       <= FRAME_RST;
      frame_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      car_pos_q     <= POS_RST;
      crash_q       <= '0;
    end else begin
      state_q       <= state_d;
      obs_q         <= obs_d;
      pos_q         <= pos_d;
      wall_hit_q    <= wall_hit_d;
      imm_q         <= imm_d;
      cnt_q         <= cnt_d;
      spawn_q       <= spawn_d;
      fmod_q        <= fmod_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      busy_q        <= busy_d;
      car_pos_q     <= car_pos_d;
      crash_q       <= crash_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    obs_d         = obs_q;
    pos_d         = pos_q;
    wall_hit_d    = wall_hit_q;
    imm_d         = imm_q;
    cnt_d         = cnt_q;
    spawn_d       = spawn_q;
    fmod_d        = fmod_q;
    frame_d       = frame_q;
    frame_valid_d = 1'b0;
    car_pos_d     = car_pos_q;
    crash_d       = '0;
    spawn_row     = '0;
    cur_pos       = '0;
    hit           = 1'b0;
    head_idx      = 0;

    case (state_q)
      S_IDLE: if (run && tick) state_d = S_SHIFT;

      S_SHIFT: begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
          for (int r = ROAD_LEN - 1; r >= 1; r--) begin
            obs_d[(p*ROAD_LEN + r)*LANE_W +: LANE_W] = obs_q[(p*ROAD_LEN + r - 1)*LANE_W +: LANE_W];
          end
        end
        state_d = S_SPAWN;
      end

      S_SPAWN: begin
        // A full row would be unpassable, so one rotating lane is always left open
        for (int p = 0; p < NUM_PLAYERS; p++) begin
          spawn_row = '0;
          if (spawn_q == 4'd0) begin
            spawn_row = rand_in[LANE_W*p +: LANE_W];
            if (&spawn_row) spawn_row = spawn_row & ~(LANE_W'(1) << fmod_q);
          end
          obs_d[(p*ROAD_LEN)*LANE_W +: LANE_W] = spawn_row;
        end
        spawn_d = (spawn_q == 4'(SPAWN_PERIOD - 1)) ? 4'd0 : spawn_q + 4'd1;
        fmod_d  = (fmod_q == 4'(LANE_W - 1)) ? 4'd0 : fmod_q + 4'd1;
        state_d = S_MOVE;
      end

      S_MOVE: begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
          cur_pos       = pos_q[4*p +: 4];
          wall_hit_d[p] = 1'b0;
          if (move[2*p +: 2] == 2'b01) begin
            if (cur_pos == 4'd0) wall_hit_d[p] = 1'b1;
            else                 pos_d[4*p +: 4] = cur_pos - 4'd1;
          end else if (move[2*p +: 2] == 2'b10) begin
            if (cur_pos == 4'(LANE_W - 1)) wall_hit_d[p] = 1'b1;
            else                           pos_d[4*p +: 4] = cur_pos + 4'd1;
          end
        end
        state_d = S_CHECK;
      end

      S_CHECK: begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
          head_idx = (p*ROAD_LEN + HEAD_ROW)*LANE_W + 32'(pos_q[4*p +: 4]);
          hit      = obs_q[head_idx] | obs_q[head_idx + LANE_W] | wall_hit_q[p];
          if (hit && imm_q[4*p +: 4] == 4'd0) begin
            if (cnt_q[CNT_W*p +: CNT_W] != {CNT_W{1'b1}})
              cnt_d[CNT_W*p +: CNT_W] = cnt_q[CNT_W*p +: CNT_W] + CNT_W'(1);
            imm_d[4*p +: 4] = 4'(IMMUNITY);
            crash_d[p]      = 1'b1;
          end else if (imm_q[4*p +: 4] != 4'd0) begin
            imm_d[4*p +: 4] = imm_q[4*p +: 4] - 4'd1;
          end
        end
        // Outputs load on the edge into DONE so they are valid while DONE is held
        frame_d       = build_frame(obs_q, pos_q);
        car_pos_d     = pos_q;
        frame_valid_d = 1'b1;
        state_d       = S_DONE;
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign frame       = frame_q;
  assign frame_valid = frame_valid_q;
  assign busy        = busy_q;
  assign car_pos     = car_pos_q;
  assign crash       = crash_q;
  assign crash_cnt   = cnt_q;

endmodule

// File: tb/tb_car_dash_engine.sv
// Directed bench for car_dash_engine: default build (A) and a 3-player, 4-lane,
// zero-immunity build (B) driven from a shared clock, reset, run and tick.
module tb_car_dash_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, run, tick;

  logic [3:0]   move_a;
  logic [11:0]  rand_a;
  logic [383:0] frame_a;
  logic         fv_a, busy_a;
  logic [7:0]   pos_a;
  logic [1:0]   crash_a;
  logic [11:0]  cnt_a;

  logic [5:0]   move_b;
  logic [11:0]  rand_b;
  logic [431:0] frame_b;
  logic         fv_b, busy_b;
  logic [11:0]  pos_b;
  logic [2:0]   crash_b;
  logic [17:0]  cnt_b;

  int checks = 0;
  int errors = 0;

  int       fv_cnt, fvb_cnt, fv_idx;
  logic     busy_seen;
  logic [1:0] cr_a;
  logic [2:0] cr_b;

  car_dash_engine dut_a (
    .clk(clk), .RST(rst), .run(run), .tick(tick), .move(move_a), .rand_in(rand_a),
    .frame(frame_a), .frame_valid(fv_a), .busy(busy_a), .car_pos(pos_a),
    .crash(crash_a), .crash_cnt(cnt_a)
  );

  car_dash_engine #(.NUM_PLAYERS(3), .LANE_W(4), .IMMUNITY(0)) dut_b (
    .clk(clk), .RST(rst), .run(run), .tick(tick), .move(move_b), .rand_in(rand_b),
    .frame(frame_b), .frame_valid(fv_b), .busy(busy_b), .car_pos(pos_b),
    .crash(crash_b), .crash_cnt(cnt_b)
  );

  // Expected A frame with no obstacles: walls plus both cars
  function automatic logic [383:0] base_frame(input int p0, input int p1);
    logic [383:0] f;
    f = '0;
    for (int p = 0; p < 2; p++) begin
      for (int r = 0; r < 24; r++) begin
        f[(p*24 + r)*8]     = 1'b1;
        f[(p*24 + r)*8 + 7] = 1'b1;
      end
      f[(p*24 + 16)*8 + ((p == 0) ? p0 : p1) + 1] = 1'b1;
      f[(p*24 + 17)*8 + ((p == 0) ? p0 : p1) + 1] = 1'b1;
    end
    return f;
  endfunction

  function automatic logic [7:0] row_a(input int p, input int r);
    return frame_a[(p*24 + r)*8 +: 8];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One tick and a fixed 7-cycle observation window
  task automatic frame_tick();
    fv_cnt = 0; fvb_cnt = 0; fv_idx = 0; busy_seen = 1'b0; cr_a = '0; cr_b = '0;
    @(negedge clk);
    tick = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      tick = 1'b0;
      if (fv_a) begin fv_cnt++; fv_idx = i; end
      if (fv_b) fvb_cnt++;
      busy_seen = busy_seen | busy_a;
      cr_a = cr_a | crash_a;
      cr_b = cr_b | crash_b;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pos_a !== 8'h33) begin errors++; $display("FAIL reset_pos_a got %h exp 33", pos_a); end
    checks++; if (cnt_a !== 12'h000) begin errors++; $display("FAIL reset_cnt_a got %h exp 000", cnt_a); end
    checks++; if (frame_a !== base_frame(3, 3)) begin errors++; $display("FAIL reset_frame_a got %h", frame_a); end
    checks++; if ({busy_a, fv_a, crash_a} !== 4'b0000) begin errors++; $display("FAIL reset_flags_a got %b exp 0000", {busy_a, fv_a, crash_a}); end
    checks++; if (pos_b !== 12'h222) begin errors++; $display("FAIL reset_pos_b got %h exp 222", pos_b); end
    checks++; if (cnt_b !== 18'h0) begin errors++; $display("FAIL reset_cnt_b got %h exp 0", cnt_b); end
    checks++; if (frame_b[(2*24 + 16)*6 +: 6] !== 6'h29) begin errors++; $display("FAIL reset_frame_b got %h exp 29", frame_b[(2*24 + 16)*6 +: 6]); end
  endtask

  task automatic test_wall();
    int ep0[10] = '{2, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    int ep1[10] = '{4, 5, 5, 5, 5, 5, 5, 5, 5, 5};
    int ec0[10] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2};
    int ec1[10] = '{0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
    logic [1:0] ecr[10] = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00};
    do_reset();
    run = 1'b1; rand_a = '0; move_a = 4'b1001;
    for (int t = 0; t < 10; t++) begin
      frame_tick();
      checks++; if (fv_cnt !== 1) begin errors++; $display("FAIL wall_fv t%0d got %0d exp 1", t+1, fv_cnt); end
      checks++; if (pos_a !== {4'(ep1[t]), 4'(ep0[t])}) begin errors++; $display("FAIL wall_pos t%0d got %h exp %0d%0d", t+1, pos_a, ep1[t], ep0[t]); end
      checks++; if (cnt_a !== {6'(ec1[t]), 6'(ec0[t])}) begin errors++; $display("FAIL wall_cnt t%0d got %h exp %0d/%0d", t+1, cnt_a, ec1[t], ec0[t]); end
      checks++; if (cr_a !== ecr[t]) begin errors++; $display("FAIL wall_crash t%0d got %b exp %b", t+1, cr_a, ecr[t]); end
    end
  endtask

  task automatic test_obstacle();
    do_reset();
    run = 1'b1; move_a = 4'b0000; rand_a = 12'h008;
    for (int t = 1; t <= 18; t++) begin
      frame_tick();
      rand_a = '0;
      if (t == 1) begin
        checks++; if (row_a(0, 0) !== 8'h91) begin errors++; $display("FAIL obs_row0_p0 got %h exp 91", row_a(0, 0)); end
        checks++; if (row_a(1, 0) !== 8'h81) begin errors++; $display("FAIL obs_row0_p1 got %h exp 81", row_a(1, 0)); end
      end
      if (t <= 16) begin
        checks++; if (cr_a !== 2'b00) begin errors++; $display("FAIL obs_early_crash t%0d got %b exp 00", t, cr_a); end
      end
      if (t == 16) begin
        checks++; if (row_a(0, 15) !== 8'h91) begin errors++; $display("FAIL obs_row15 got %h exp 91", row_a(0, 15)); end
      end
      if (t == 17) begin
        checks++; if (cr_a !== 2'b01) begin errors++; $display("FAIL obs_hit_crash got %b exp 01", cr_a); end
        checks++; if (cnt_a !== 12'h001) begin errors++; $display("FAIL obs_hit_cnt got %h exp 001", cnt_a); end
      end
      if (t == 18) begin
        checks++; if (cr_a !== 2'b00) begin errors++; $display("FAIL obs_tail_crash got %b exp 00", cr_a); end
        checks++; if (cnt_a !== 12'h001) begin errors++; $display("FAIL obs_tail_cnt got %h exp 001", cnt_a); end
      end
    end
  endtask

  task automatic test_gap_and_run();
    logic [383:0] saved;
    int idle_fv;
    do_reset();
    run = 1'b1; move_a = 4'b0000; rand_a = 12'hFFF;
    frame_tick();
    checks++; if (row_a(0, 0) !== 8'hFD) begin errors++; $display("FAIL gap_t1_p0 got %h exp FD", row_a(0, 0)); end
    checks++; if (row_a(1, 0) !== 8'hFD) begin errors++; $display("FAIL gap_t1_p1 got %h exp FD", row_a(1, 0)); end
    for (int t = 2; t <= 4; t++) frame_tick();
    checks++; if (row_a(0, 0) !== 8'h81) begin errors++; $display("FAIL gap_nospawn got %h exp 81", row_a(0, 0)); end
    checks++; if (row_a(0, 3) !== 8'hFD) begin errors++; $display("FAIL gap_row3 got %h exp FD", row_a(0, 3)); end
    frame_tick();
    checks++; if (row_a(0, 0) !== 8'hDF) begin errors++; $display("FAIL gap_t5_p0 got %h exp DF", row_a(0, 0)); end
    checks++; if (row_a(1, 0) !== 8'hDF) begin errors++; $display("FAIL gap_t5_p1 got %h exp DF", row_a(1, 0)); end
    checks++; if (row_a(0, 4) !== 8'hFD) begin errors++; $display("FAIL gap_row4 got %h exp FD", row_a(0, 4)); end
    saved = frame_a;
    run = 1'b0; idle_fv = 0;
    for (int k = 0; k < 3; k++) begin
      frame_tick();
      idle_fv = idle_fv + fv_cnt + int'(busy_seen);
    end
    checks++; if (idle_fv !== 0) begin errors++; $display("FAIL run0_activity got %0d exp 0", idle_fv); end
    checks++; if (frame_a !== saved) begin errors++; $display("FAIL run0_frame changed got %h", frame_a); end
    run = 1'b1;
    frame_tick();
    checks++; if (row_a(0, 0) !== 8'h81) begin errors++; $display("FAIL run0_spawncnt got %h exp 81", row_a(0, 0)); end
    checks++; if (row_a(0, 1) !== 8'hDF) begin errors++; $display("FAIL run0_row1 got %h exp DF", row_a(0, 1)); end
    checks++; if (row_a(0, 5) !== 8'hFD) begin errors++; $display("FAIL run0_row5 got %h exp FD", row_a(0, 5)); end
  endtask

  task automatic test_busy_and_rst();
    int busy_cycles;
    int late_fv;
    do_reset();
    run = 1'b1; move_a = 4'b0000; rand_a = '0;
    fv_cnt = 0; fv_idx = 0; busy_cycles = 0;
    @(negedge clk);
    tick = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      tick = (i == 2);
      if (fv_a) begin fv_cnt++; fv_idx = i; end
      if (busy_a) busy_cycles++;
    end
    tick = 1'b0;
    checks++; if (fv_cnt !== 1) begin errors++; $display("FAIL busy_fv_count got %0d exp 1", fv_cnt); end
    checks++; if (fv_idx !== 5) begin errors++; $display("FAIL busy_latency got %0d exp 5", fv_idx); end
    checks++; if (busy_cycles !== 5) begin errors++; $display("FAIL busy_len got %0d exp 5", busy_cycles); end

    move_a = 4'b0101;
    frame_tick();
    checks++; if (pos_a !== 8'h22) begin errors++; $display("FAIL rst_pre_pos got %h exp 22", pos_a); end
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if ({busy_a, fv_a} !== 2'b00) begin errors++; $display("FAIL rst_mid_flags got %b exp 00", {busy_a, fv_a}); end
    checks++; if (pos_a !== 8'h33) begin errors++; $display("FAIL rst_mid_pos got %h exp 33", pos_a); end
    checks++; if (frame_a !== base_frame(3, 3)) begin errors++; $display("FAIL rst_mid_frame got %h", frame_a); end
    @(negedge clk);
    rst = 1'b0;
    late_fv = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (fv_a) late_fv++;
    end
    checks++; if (late_fv !== 0) begin errors++; $display("FAIL rst_mid_late_fv got %0d exp 0", late_fv); end
  endtask

  task automatic test_param_build();
    do_reset();
    run = 1'b1; move_b = 6'b100001; rand_b = '0;
    for (int t = 1; t <= 70; t++) begin
      frame_tick();
      if (t == 3) begin
        checks++; if (cnt_b !== {6'd2, 6'd0, 6'd1}) begin errors++; $display("FAIL b_cnt_t3 got %h", cnt_b); end
      end
      if (t == 10) begin
        checks++; if (fvb_cnt !== 1) begin errors++; $display("FAIL b_fv_t10 got %0d exp 1", fvb_cnt); end
        checks++; if (pos_b !== 12'h320) begin errors++; $display("FAIL b_pos_t10 got %h exp 320", pos_b); end
        checks++; if (cnt_b !== {6'd9, 6'd0, 6'd8}) begin errors++; $display("FAIL b_cnt_t10 got %h", cnt_b); end
        checks++; if (cr_b !== 3'b101) begin errors++; $display("FAIL b_crash_t10 got %b exp 101", cr_b); end
      end
      if (t == 64) begin
        checks++; if (cnt_b !== {6'd63, 6'd0, 6'd62}) begin errors++; $display("FAIL b_cnt_t64 got %h", cnt_b); end
      end
      if (t == 65) begin
        checks++; if (cnt_b !== {6'd63, 6'd0, 6'd63}) begin errors++; $display("FAIL b_cnt_t65 got %h", cnt_b); end
      end
      if (t == 70) begin
        checks++; if (cnt_b !== {6'd63, 6'd0, 6'd63}) begin errors++; $display("FAIL b_cnt_sat got %h", cnt_b); end
        checks++; if (cr_b !== 3'b101) begin errors++; $display("FAIL b_crash_t70 got %b exp 101", cr_b); end
        checks++; if (pos_b !== 12'h320) begin errors++; $display("FAIL b_pos_t70 got %h exp 320", pos_b); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; tick = 1'b0;
    move_a = '0; rand_a = '0; move_b = '0; rand_b = '0;
    test_reset();
    test_wall();
    test_obstacle();
    test_gap_and_run();
    test_busy_and_rst();
    test_param_build();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
